fifo_tx: RTL
============

// Module: fifo_tx
// PURPOSE
//   Transmit-side byte FIFO (counterpart of the receive FIFO), parallel-in / serial-out.
//   CPU pushes bytes through an APB write-only slave port. Bytes are serialised LSB first
//   toward the spreader/modulator, one bit per rising edge of en_bit from the bit-rate generator.
// PARAMETERS
//   WIDTH  8   data width in bits; serialiser bit counter sized $clog2(WIDTH)
//   DEPTH  64  FIFO entries, power of 2; PTR_WIDTH=$clog2(DEPTH), pointers PTR_WIDTH+1 bits
// PORTS
//   clk       in   1      system clock; everything synchronous to its rising edge
//   reset     in   1      synchronous reset, active-high
//   psel      in   1      APB select
//   penable   in   1      APB enable (access phase)
//   pwrite    in   1      APB direction; 1 = write
//   pwdata    in   WIDTH  APB write data
//   pready    out  1      tied 1; no wait states
//   pslverr   out  1      write rejected, FIFO full
//   en_bit    in   1      bit strobe; 0->1 edge = one bit period elapsed
//   data_out  out  1      serial bit to spreader
//   tx_busy   out  1      1 while a byte is loaded or shifting
// BEHAVIOUR
//   Reset (sync, high): wr_ptr=rd_ptr=0, state=IDLE, shift_reg=0, bit_cnt=0, en_bit_d=0;
//     data_out=0, tx_busy=0; pslverr=0 unless full access; mem contents not cleared.
//   Flags from registered pointers: empty = ptrs equal incl. MSB;
//     full = low PTR_WIDTH bits equal, MSB differs.
//   Write: wr_en = psel&penable&pwrite&~full -> mem[wr_ptr]<=pwdata, wr_ptr+1 (wraps mod 2*DEPTH).
//   pslverr = psel&penable&pwrite&full (comb, access phase); data dropped, ptrs unchanged.
//     No overwrite of oldest entry. Reads (pwrite=0) ignored, pslverr=0.
//   bit_tick = en_bit & ~en_bit_d (en_bit_d registered). en_bit held high = one tick only.
//   FSM:
//     IDLE : data_out=0, tx_busy=0; ~empty -> LOAD next cycle.
//     LOAD : 1 cycle; shift_reg<=mem[rd_ptr[PTR_WIDTH-1:0]], rd_ptr+1, bit_cnt<=0 -> SHIFT.
//     SHIFT: data_out=shift_reg[0]; on bit_tick shift_reg>>=1, bit_cnt+1.
//            On bit_tick with bit_cnt==WIDTH-1: ~empty -> LOAD, else -> IDLE.
//   tx_busy=1 in LOAD and SHIFT. bit_tick in IDLE/LOAD ignored (en_bit period >= 4 clk).
//   Bit k of a byte is on data_out for the bit period ending at tick k+1 (LSB = k=0).
//   Simultaneous write + LOAD: both pointers update same cycle; full/empty from pre-update values.
//     Write seen full in that cycle is still rejected.
//   Capacity: DEPTH in FIFO + 1 in shift_reg.
//   Reset mid-byte: byte in flight and FIFO contents discarded; data_out=0 next cycle.
// CONFIGURATION
//   FIFO_TX_LEVEL_EN defined: extra output port
//     level  out  PTR_WIDTH+1  = wr_ptr - rd_ptr (0..DEPTH), combinational from registered ptrs.
//   Not defined: port absent, no subtractor; all other behaviour identical.
// TESTING
//   1. Reset, APB write 0xA5, 8 en_bit pulses -> data_out 1,0,1,0,0,1,0,1; tx_busy falls after tick 8, data_out=0.
//   2. en_bit low, 70 back-to-back writes 0x00..0x45 -> 65 accepted (0x00..0x40), writes 66-70 pslverr=1;
//      level=64 (LEVEL_EN); then drain: bytes out in order 0x00..0x40.
//   3. FIFO full, write issued in LOAD cycle -> rejected, pslverr=1; next write accepted, pslverr=0.
//   4. Write 0x3C, en_bit held high 20 clk then low -> exactly one bit shifted; bit_cnt=1.
//   5. Write 0xFF,0x81; reset after 3 ticks -> data_out=0, tx_busy=0, empty; write 0x01 -> sent 1,0,0,0,0,0,0,0.
//   6. APB read (pwrite=0) to full FIFO -> pslverr=0, no pointer change.

Source files
------------

// File: rtl/fifo_tx_if.sv
// APB write-only slave bundle used by the transmit FIFO.
//   psel, penable, pwrite, pwdata : driven by the bus master (CPU side)
//   pready                        : always 1, the slave has no wait states
//   pslverr                       : write rejected because the FIFO was full
interface fifo_tx_if #(
  parameter int unsigned WIDTH = 8
);
  logic             psel;
  logic             penable;
  logic             pwrite;
  logic [WIDTH-1:0] pwdata;
  logic             pready;
  logic             pslverr;

  modport master (
    output psel,
    output penable,
    output pwrite,
    output pwdata,
    input  pready,
    input  pslverr
  );

  modport slave (
    input  psel,
    input  penable,
    input  pwrite,
    input  pwdata,
    output pready,
    output pslverr
  );
endinterface

// File: rtl/fifo_tx.sv
// Transmit-side byte FIFO, parallel-in / serial-out.
// The CPU pushes bytes over an APB write-only slave port; bytes are serialised LSB first,
// one bit per rising edge of en_bit from the bit-rate generator.
// Ports:
//   clk      : system clock, everything on its rising edge
//   reset    : synchronous reset, active-high
//   apb      : APB slave bundle (psel/penable/pwrite/pwdata in, pready/pslverr out)
//   en_bit   : bit strobe; each 0->1 edge ends one bit period
//   data_out : serial bit toward the spreader
//   tx_busy  : high while a byte is being loaded or shifted
//   level    : FIFO fill level 0..DEPTH (only when FIFO_TX_LEVEL_EN is defined)
// Build option: define FIFO_TX_LEVEL_EN to add the level output.
module fifo_tx #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  fifo_tx_if.slave                apb,
  input  logic                    en_bit,
  output logic                    data_out,
  output logic                    tx_busy
`ifdef FIFO_TX_LEVEL_EN
  ,
  output logic [$clog2(DEPTH):0]  level
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned BitW = $clog2(WIDTH);
  localparam logic [PtrW:0] PtrOne = 1;
  localparam logic [BitW-1:0] BitOne = 1;
  localparam logic [BitW-1:0] BitLast = BitW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StShift} state_e;

  state_e           state_q, state_d;
  logic [PtrW:0]    wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]    rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;
  logic             en_bit_q;
  logic [WIDTH-1:0] mem [DEPTH];

  logic empty, full, wr_en, bit_tick;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]) &&
                    (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]);
  assign wr_en    = apb.psel & apb.penable & apb.pwrite & ~full;
  assign bit_tick = en_bit & ~en_bit_q;

  assign apb.pready  = 1'b1;
  assign apb.pslverr = apb.psel & apb.penable & apb.pwrite & full;

`ifdef FIFO_TX_LEVEL_EN
  assign level = wr_ptr_q - rd_ptr_q;
`endif

  always_comb begin
    state_d   = state_q;
    rd_ptr_d  = rd_ptr_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    wr_ptr_d  = wr_en ? (wr_ptr_q + PtrOne) : wr_ptr_q;
    data_out  = 1'b0;
    tx_busy   = 1'b0;
    case (state_q)
      StIdle: begin
        if (!empty) state_d = StLoad;
      end
      StLoad: begin
        tx_busy   = 1'b1;
        shift_d   = mem[rd_ptr_q[PtrW-1:0]];
        rd_ptr_d  = rd_ptr_q + PtrOne;
        bit_cnt_d = '0;
        state_d   = StShift;
      end
      StShift: begin
        tx_busy  = 1'b1;
        data_out = shift_q[0];
        if (bit_tick) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + BitOne;
          if (bit_cnt_q == BitLast) state_d = empty ? StIdle : StLoad;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      en_bit_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      en_bit_q  <= en_bit;
    end
  end

  // Storage is never cleared; the pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q[PtrW-1:0]] <= apb.pwdata;
  end

endmodule
